// File: rtl/ws2812_pkg.sv
// Shared types and timing defaults for the WS2812 refresh path.
// Counter width helper sizes every scheduler timer.
package ws2812_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ARM,
    RUN,
    LATCH
  } state_t;

  localparam int NUM_LAYERS_DEF    = 8;
  localparam int FRAME_TICKS_DEF   = 1333333;
  localparam int LATCH_TICKS_DEF   = 24000;
  localparam int TIMEOUT_TICKS_DEF = 400000;
  localparam int ARM_TICKS_DEF     = 2;

  function automatic int cnt_w(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/ws2812_tick_timer.sv
// Loadable down-counter that holds at zero.
// done is high whenever the count sits at zero.
module ws2812_tick_timer #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt;

  // Reload beats counting; the count never wraps below zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/ws2812_refresh_scheduler.sv
// Frame sequencer for the layer engines: start, run, latch gap.
// Holds the RAM write lock while engines read the frame.
module ws2812_refresh_scheduler
  import ws2812_pkg::*;
#(
  parameter int NUM_LAYERS    = NUM_LAYERS_DEF,
  parameter int FRAME_TICKS   = FRAME_TICKS_DEF,
  parameter int LATCH_TICKS   = LATCH_TICKS_DEF,
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
  parameter int ARM_TICKS     = ARM_TICKS_DEF
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  auto_en_in,
  input  logic                  frame_req_in,
  input  logic [NUM_LAYERS-1:0] layer_mask_in,
  input  logic [NUM_LAYERS-1:0] layer_busy_in,
  input  logic                  err_clr_in,
  output logic [NUM_LAYERS-1:0] read_en_out,
  output logic                  wr_lock_out,
  output logic                  busy_out,
  output logic                  frame_done_out,
  output logic                  timeout_err_out
);

  localparam int W = cnt_w(FRAME_TICKS, LATCH_TICKS,
                           TIMEOUT_TICKS);

  state_t                state;
  logic [NUM_LAYERS-1:0] active_mask;
  logic                  pending;
  logic                  tick;
  logic                  trig;
  logic                  req;
  logic                  run_idle;
  logic                  ph_load;
  logic [W-1:0]          ph_val;
  logic                  ph_done;

  // Remaining-count form: elapsed 0 at reset, tick at elapsed N-1.
  ws2812_tick_timer #(
    .W       (W),
    .RST_VAL (W'(FRAME_TICKS - 1))
  ) u_frame_timer (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .load     (tick),
    .load_val (W'(FRAME_TICKS - 1)),
    .en       (1'b1),
    .done     (tick)
  );

  ws2812_tick_timer #(
    .W       (W),
    .RST_VAL ('0)
  ) u_phase_timer (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .load     (ph_load),
    .load_val (ph_val),
    .en       (1'b1),
    .done     (ph_done)
  );

  assign trig     = frame_req_in | (auto_en_in & tick);
  assign req      = trig | pending;
  assign run_idle = ~|(layer_busy_in & active_mask);

  // Preload the phase counter with the next state's length minus one.
  always_comb begin
    ph_load = 1'b0;
    ph_val  = '0;
    unique case (state)
      START: begin
        ph_load = 1'b1;
        ph_val  = W'(ARM_TICKS - 1);
      end
      ARM: begin
        if (ph_done) begin
          ph_load = 1'b1;
          ph_val  = W'(TIMEOUT_TICKS - 1);
        end
      end
      RUN: begin
        if (ph_done || run_idle) begin
          ph_load = 1'b1;
          ph_val  = W'(LATCH_TICKS - 1);
        end
      end
      default: begin
        ph_load = 1'b0;
      end
    endcase
  end

  // Frame sequencer with registered outputs and one-deep pending.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state           <= IDLE;
      pending         <= 1'b0;
      active_mask     <= '0;
      read_en_out     <= '0;
      wr_lock_out     <= 1'b0;
      busy_out        <= 1'b0;
      frame_done_out  <= 1'b0;
      timeout_err_out <= 1'b0;
    end else begin
      read_en_out    <= '0;
      frame_done_out <= 1'b0;
      if (err_clr_in) timeout_err_out <= 1'b0;
      if (state != IDLE && trig) pending <= 1'b1;
      unique case (state)
        IDLE: begin
          if (req) begin
            pending <= 1'b0;
            if (|layer_mask_in) begin
              active_mask <= layer_mask_in;
              read_en_out <= layer_mask_in;
              wr_lock_out <= 1'b1;
              busy_out    <= 1'b1;
              state       <= START;
            end
          end
        end
        START: begin
          state <= ARM;
        end
        ARM: begin
          if (ph_done) state <= RUN;
        end
        RUN: begin
          if (ph_done) begin
            timeout_err_out <= 1'b1;
            wr_lock_out     <= 1'b0;
            state           <= LATCH;
          end else if (run_idle) begin
            wr_lock_out <= 1'b0;
            state       <= LATCH;
          end
        end
        LATCH: begin
          if (ph_done) begin
            frame_done_out <= 1'b1;
            busy_out       <= 1'b0;
            state          <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_refresh_scheduler.sv
// Directed bench for the WS2812 refresh scheduler.
// Small timing parameters; expected gaps are hand-derived.
module tb_ws2812_refresh_scheduler;

  localparam int NL = 8;
  localparam int W_RE = 0;
  localparam int W_DONE = 1;
  localparam int W_ERR = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          auto_en;
  logic          frame_req;
  logic [NL-1:0] mask;
  logic [NL-1:0] busy;
  logic          err_clr;
  logic [NL-1:0] read_en;
  logic          wr_lock;
  logic          busy_o;
  logic          done;
  logic          err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ws2812_refresh_scheduler #(
    .NUM_LAYERS    (NL),
    .FRAME_TICKS   (100),
    .LATCH_TICKS   (10),
    .TIMEOUT_TICKS (50),
    .ARM_TICKS     (2)
  ) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .auto_en_in      (auto_en),
    .frame_req_in    (frame_req),
    .layer_mask_in   (mask),
    .layer_busy_in   (busy),
    .err_clr_in      (err_clr),
    .read_en_out     (read_en),
    .wr_lock_out     (wr_lock),
    .busy_out        (busy_o),
    .frame_done_out  (done),
    .timeout_err_out (err)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_for(
    input  int sel,
    input  int lim,
    output int n,
    output int nd
  );
    logic hit;
    n  = 0;
    nd = 0;
    do begin
      step(1);
      n++;
      if (done) nd++;
      hit = (sel == W_RE)   ? |read_en :
            (sel == W_DONE) ? done : err;
    end while (!hit && n < lim);
  endtask

  task automatic window(
    input  int len,
    output int n_re,
    output int n_done,
    output int n_busy
  );
    n_re   = 0;
    n_done = 0;
    n_busy = 0;
    for (int i = 0; i < len; i++) begin
      step(1);
      if (|read_en) n_re++;
      if (done) n_done++;
      if (busy_o) n_busy++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_read_en"}, read_en, 0);
    check({tag, "_wr_lock"}, wr_lock, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nd;
    int a;
    int b;
    int c;
    rst_n     = 1'b0;
    auto_en   = 1'b0;
    frame_req = 1'b0;
    err_clr   = 1'b0;
    mask      = '0;
    busy      = '0;
    step(3);
    check_all_zero("rst");
    rst_n = 1'b1;
    step(5);

    // basic frame; bit 3 busy lies outside the mask
    mask      = 8'h05;
    frame_req = 1'b1;
    step(1);
    frame_req = 1'b0;
    busy      = 8'h0D;
    check("t1_read_en", read_en, 8'h05);
    check("t1_wr_lock", wr_lock, 1);
    check("t1_busy", busy_o, 1);
    step(1);
    check("t1_read_en_pulse", read_en, 0);
    step(19);
    check("t1_lock_run", wr_lock, 1);
    busy = 8'h08;
    step(1);
    check("t1_lock_fall", wr_lock, 0);
    wait_for(W_DONE, 40, n, nd);
    check("t1_done_gap", n, 10);
    step(1);
    check("t1_done_pulse", done, 0);
    check("t1_idle", busy_o, 0);
    busy = '0;

    // overrun: three requests in RUN give one extra frame
    mask      = 8'h01;
    frame_req = 1'b1;
    step(1);
    frame_req = 1'b0;
    busy      = 8'h01;
    check("t3_read_en", read_en, 8'h01);
    step(5);
    repeat (3) begin
      frame_req = 1'b1;
      step(1);
      frame_req = 1'b0;
      step(2);
    end
    busy = '0;
    wait_for(W_DONE, 40, n, nd);
    check("t3_done1_gap", n, 11);
    step(1);
    check("t3_restart", read_en, 8'h01);
    wait_for(W_DONE, 40, n, nd);
    check("t3_done2_gap", n, 14);
    window(40, a, b, c);
    check("t3_no_third", a, 0);

    // timeout with a stuck engine
    mask      = 8'h08;
    busy      = 8'h08;
    frame_req = 1'b1;
    step(1);
    frame_req = 1'b0;
    check("t4_read_en", read_en, 8'h08);
    wait_for(W_ERR, 100, n, nd);
    check("t4_err_gap", n, 53);
    check("t4_lock", wr_lock, 0);
    wait_for(W_DONE, 40, n, nd);
    check("t4_done_gap", n, 10);
    check("t4_err_sticky", err, 1);
    busy    = '0;
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("t4_err_clr", err, 0);

    // zero mask request is dropped
    mask      = '0;
    frame_req = 1'b1;
    step(1);
    frame_req = 1'b0;
    check("t5_zero_read_en", read_en, 0);
    check("t5_zero_busy", busy_o, 0);
    window(30, a, b, c);
    check("t5_zero_pulses", a, 0);
    check("t5_zero_done", b, 0);
    check("t5_zero_busyw", c, 0);

    // auto refresh period
    mask    = 8'hFF;
    auto_en = 1'b1;
    wait_for(W_RE, 150, n, nd);
    check("t2_value", read_en, 8'hFF);
    wait_for(W_RE, 150, n, nd);
    check("t2_period1", n, 100);
    wait_for(W_RE, 150, n, nd);
    check("t2_period2", n, 100);

    // request on the tick cycle merges into one frame
    step(99);
    frame_req = 1'b1;
    step(1);
    frame_req = 1'b0;
    check("t5_coinc_read_en", read_en, 8'hFF);
    window(90, a, b, c);
    check("t5_coinc_single", a, 0);
    check("t5_coinc_done", b, 1);

    // reset in RUN aborts the frame
    auto_en   = 1'b0;
    mask      = 8'h01;
    busy      = 8'h01;
    frame_req = 1'b1;
    step(1);
    frame_req = 1'b0;
    step(6);
    check("t6_pre_busy", busy_o, 1);
    check("t6_pre_lock", wr_lock, 1);
    rst_n = 1'b0;
    step(1);
    check_all_zero("t6_rst");
    rst_n   = 1'b1;
    busy    = '0;
    auto_en = 1'b1;
    wait_for(W_RE, 150, n, nd);
    check("t6_first_tick", n, 100);
    check("t6_no_done", nd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
